// File: rtl/iic_reg_responder.sv
// iic_reg_responder
//   I2C target register file answering at DEV_ADDR. SCL/SDA are oversampled on
//   clk (2-FF sync + one delayed copy for edge detect). Writes go
//   {dev,0}, pointer, data...; reads go {dev,1} and stream bank[pointer++].
//   The pointer wraps at 2**ADDR_W and is retained between transfers.
// Ports
//   clk, rst_n              system clock (>= 8x SCL), async active-low reset
//   scl_i, sda_i            asynchronous pad inputs
//   sda_o                   open-drain control: 0 = pull low, 1 = release
//   busy                    address-matched transfer in progress
//   reg_wr_en/addr/data     one-cycle pulse per byte written over I2C
//   dbg_addr -> dbg_data    combinational fabric-side read of the bank
`timescale 1ns/1ps
module iic_reg_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h76,
    parameter int         ADDR_W   = 6,
    parameter int         HOLD_CYC = 2    // must be >= 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_o,
    output logic              busy,
    output logic              reg_wr_en,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [7:0]        reg_wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int HW    = $clog2(HOLD_CYC + 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYC);

    typedef enum logic [3:0] {
        S_IDLE, S_DEV_ADDR, S_ACK_ADDR, S_REG_PTR, S_ACK_PTR,
        S_WR_DATA, S_ACK_WR, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    state_t            state, state_nxt;
    logic [1:0]        scl_sync, sda_sync;
    logic              scl_d, sda_d, scl_s, sda_s;
    logic              scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]        bit_cnt;
    logic [7:0]        sh, tx;
    logic [ADDR_W-1:0] ptr;
    logic              got_ack, sda_q, sda_want;
    logic [HW-1:0]     hold_cnt;
    logic [7:0]        bank [DEPTH];
    logic              byte_done, ptr_load, wr_fire, rd_load;

    // ---------------- input synchronisers / event decode ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    assign scl_s     = scl_sync[1];
    assign sda_s     = sda_sync[1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    // SDA edges only count as START/STOP while SCL is stably high
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign byte_done = (bit_cnt == 4'd8);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // Byte/ack boundaries are taken on SCL falls so every state spans whole
    // low phases; START/STOP pre-empt everything, which aborts partial bytes.
    always_comb begin
        state_nxt = state;
        if (start_det)     state_nxt = S_DEV_ADDR;
        else if (stop_det) state_nxt = S_IDLE;
        else begin
            case (state)
                S_DEV_ADDR: if (scl_fall && byte_done)
                                state_nxt = (sh[7:1] == DEV_ADDR) ? S_ACK_ADDR : S_IGNORE;
                S_ACK_ADDR: if (scl_fall) state_nxt = sh[0] ? S_RD_DATA : S_REG_PTR;
                S_REG_PTR:  if (scl_fall && byte_done) state_nxt = S_ACK_PTR;
                S_ACK_PTR:  if (scl_fall) state_nxt = S_WR_DATA;
                S_WR_DATA:  if (scl_fall && byte_done) state_nxt = S_ACK_WR;
                S_ACK_WR:   if (scl_fall) state_nxt = S_WR_DATA;
                S_RD_DATA:  if (scl_fall && byte_done) state_nxt = S_RD_ACK;
                S_RD_ACK: begin
                    if (scl_rise && sda_s)       state_nxt = S_IGNORE;
                    else if (scl_fall && got_ack) state_nxt = S_RD_DATA;
                end
                default: ;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        sda_want = 1'b1;
        case (state)
            S_ACK_ADDR, S_ACK_PTR, S_ACK_WR: sda_want = 1'b0;
            S_RD_DATA:                       sda_want = tx[7];
            default: ;
        endcase
    end

    assign ptr_load = (state == S_REG_PTR) && (state_nxt == S_ACK_PTR);
    assign wr_fire  = (state == S_WR_DATA) && (state_nxt == S_ACK_WR);
    assign rd_load  = (state != S_RD_DATA) && (state_nxt == S_RD_DATA);

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            sh          <= '0;
            tx          <= '0;
            ptr         <= '0;
            got_ack     <= 1'b0;
            reg_wr_en   <= 1'b0;
            reg_wr_addr <= '0;
            reg_wr_data <= '0;
        end else begin
            reg_wr_en <= 1'b0;
            if (start_det || stop_det) begin
                bit_cnt <= '0;
                got_ack <= 1'b0;
            end else begin
                case (state)
                    S_DEV_ADDR, S_REG_PTR, S_WR_DATA: begin
                        if (scl_rise) begin
                            sh      <= {sh[6:0], sda_s};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && byte_done) begin
                            bit_cnt <= '0;
                        end
                    end
                    S_RD_DATA: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        else if (scl_fall) begin
                            if (byte_done) bit_cnt <= '0;
                            else           tx <= {tx[6:0], 1'b0};
                        end
                    end
                    // master ACK: advance now so the next fall loads the next byte
                    S_RD_ACK: if (scl_rise && !sda_s) begin
                        got_ack <= 1'b1;
                        ptr     <= ptr + ADDR_W'(1);
                    end
                    default: ;
                endcase
                if (ptr_load) ptr <= sh[ADDR_W-1:0];
                if (wr_fire) begin
                    reg_wr_en   <= 1'b1;
                    reg_wr_addr <= ptr;
                    reg_wr_data <= sh;
                    ptr         <= ptr + ADDR_W'(1);
                end
                if (rd_load) begin
                    tx      <= bank[ptr];
                    got_ack <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
        end else if (wr_fire) begin
            bank[ptr] <= sh;
        end
    end

    assign dbg_data = bank[dbg_addr];

    // ---------------- SDA driver ----------------
    // New drive value is committed HOLD_CYC clocks after the detected fall;
    // START/STOP and reset release the line at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_q    <= 1'b1;
            hold_cnt <= '0;
        end else if (start_det || stop_det) begin
            sda_q    <= 1'b1;
            hold_cnt <= '0;
        end else if (scl_fall) begin
            hold_cnt <= HOLD_INIT;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
            if (hold_cnt == HW'(1)) sda_q <= sda_want;
        end
    end

    assign sda_o = sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                             busy <= 1'b0;
        else if (state_nxt == S_ACK_ADDR)                       busy <= 1'b1;
        else if (state_nxt == S_IDLE || state_nxt == S_IGNORE) busy <= 1'b0;
    end
endmodule

// File: tb/tb_iic_reg_responder.sv
// Directed bench: a bit-banged I2C master on a wired-AND SDA bus.
`timescale 1ns/1ps
module tb_iic_reg_responder;
    localparam int Q = 100;   // quarter SCL period = 10 clk

    logic       clk = 1'b0, rst_n = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
    logic       sda_o, busy, reg_wr_en, sda_bus;
    logic [5:0] reg_wr_addr, dbg_addr = 6'h3F;
    logic [7:0] reg_wr_data, dbg_data;

    assign sda_bus = sda_m & sda_o;
    always #5 clk = ~clk;

    iic_reg_responder dut (
        .clk(clk), .rst_n(rst_n), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_o),
        .busy(busy), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // write-pulse monitor, same-cycle dbg capture, SDA-low watch
    int         wr_cnt = 0;
    logic [5:0] last_wa = '0;
    logic [7:0] last_wd = '0, dbg_prev = '0, cap_old = 8'h55, cap_new = 8'h55;
    logic       watch = 1'b0, saw_low = 1'b0;
    always @(negedge clk) begin
        if (reg_wr_en) begin
            wr_cnt++;
            last_wa = reg_wr_addr;
            last_wd = reg_wr_data;
            if (reg_wr_addr == dbg_addr) begin
                cap_old = dbg_prev;
                cap_new = dbg_data;
            end
        end
        if (watch && !sda_o) saw_low = 1'b1;
        dbg_prev = dbg_data;
    end

    task automatic bit_x(input logic b, output logic s);
        sda_m = b; #Q; scl_m = 1'b1; #Q; s = sda_bus; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic start_c;   // also serves as repeated START
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
    endtask

    task automatic stop_c;
        sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_x(b[i], s);
        bit_x(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic last, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, s);
            d[i] = s;
        end
        bit_x(last, s);
    endtask

    logic       ack;
    logic [7:0] rd;

    initial begin
        #2;
        #50 rst_n = 1'b1; #Q;
        chk("rst_sda", sda_o, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_wren", reg_wr_en, 1'b0);
        dbg_addr = 6'h21; #1;
        chk("rst_bank21", dbg_data, 8'h00);
        dbg_addr = 6'h3F;

        // 1: single write
        start_c;
        send_byte(8'hEC, ack); chk("t1_ack_addr", ack, 1'b1);
        chk("t1_busy", busy, 1'b1);
        send_byte(8'h21, ack); chk("t1_ack_ptr", ack, 1'b1);
        send_byte(8'h09, ack); chk("t1_ack_data", ack, 1'b1);
        stop_c;
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_wr_cnt", wr_cnt, 1);
        chk("t1_wr_addr", last_wa, 6'h21);
        chk("t1_wr_data", last_wd, 8'h09);
        dbg_addr = 6'h21; #1;
        chk("t1_bank21", dbg_data, 8'h09);

        // 2: pointer wrap, dbg watching the first target byte
        dbg_addr = 6'h3F;
        start_c;
        send_byte(8'hEC, ack); send_byte(8'h3F, ack);
        send_byte(8'hA1, ack); send_byte(8'hB2, ack); chk("t2_ack", ack, 1'b1);
        stop_c;
        chk("t2_bank3f", dbg_data, 8'hA1);
        chk("t2_dbg_old", cap_old, 8'h00);
        chk("t2_dbg_new", cap_new, 8'hA1);
        dbg_addr = 6'h00; #1;
        chk("t2_bank00", dbg_data, 8'hB2);
        chk("t2_wr_cnt", wr_cnt, 3);

        // 3: fill 0x10..0x12, then read back with repeated START
        start_c;
        send_byte(8'hEC, ack); send_byte(8'h10, ack);
        send_byte(8'h5A, ack); send_byte(8'hC3, ack); send_byte(8'h7E, ack);
        stop_c;
        start_c;
        send_byte(8'hEC, ack); send_byte(8'h10, ack);
        start_c;
        send_byte(8'hED, ack); chk("t3_ack_rd", ack, 1'b1);
        read_byte(1'b0, rd); chk("t3_rd0", rd, 8'h5A);
        read_byte(1'b0, rd); chk("t3_rd1", rd, 8'hC3);
        read_byte(1'b1, rd); chk("t3_rd2", rd, 8'h7E);
        chk("t3_sda_rel", sda_o, 1'b1);
        chk("t3_busy", busy, 1'b0);
        stop_c;

        // 4: wrong address
        saw_low = 1'b0; watch = 1'b1;
        start_c;
        send_byte(8'hA0, ack); chk("t4_nack_addr", ack, 1'b0);
        chk("t4_busy", busy, 1'b0);
        send_byte(8'h55, ack); chk("t4_nack_data", ack, 1'b0);
        stop_c;
        watch = 1'b0;
        chk("t4_sda_low", saw_low, 1'b0);
        chk("t4_wr_cnt", wr_cnt, 6);

        // 5: STOP after 4 data bits, then read with retained pointer
        start_c;
        send_byte(8'hEC, ack); send_byte(8'h11, ack);
        bit_x(1'b1, ack); bit_x(1'b0, ack); bit_x(1'b1, ack); bit_x(1'b1, ack);
        stop_c;
        chk("t5_wr_cnt", wr_cnt, 6);
        chk("t5_busy", busy, 1'b0);
        dbg_addr = 6'h11; #1;
        chk("t5_bank11", dbg_data, 8'hC3);
        start_c;
        send_byte(8'hED, ack);
        read_byte(1'b1, rd); chk("t5_rd_ptr", rd, 8'hC3);
        stop_c;

        // 6: reset while driving a 0 data bit (bank[0x12] = 0x7E, MSB 0)
        start_c;
        send_byte(8'hEC, ack); send_byte(8'h12, ack);
        start_c;
        send_byte(8'hED, ack);
        chk("t6_driving", sda_o, 1'b0);
        rst_n = 1'b0; #1;
        chk("t6_sda_rel", sda_o, 1'b1);
        chk("t6_busy", busy, 1'b0);
        chk("t6_ptr", dut.ptr, 6'h00);
        dbg_addr = 6'h12; #1;
        chk("t6_bank12", dbg_data, 8'h00);
        dbg_addr = 6'h3F; #1;
        chk("t6_bank3f", dbg_data, 8'h00);
        sda_m = 1'b1; #Q; scl_m = 1'b1; #Q;
        rst_n = 1'b1; #Q;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
